// File: rtl/pea_core_if.sv
// Bundle of the PEA core's FIFO, scheduler and result-side signals.
interface pea_core_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned POP_W = 10
);
    logic [WIDTH-1:0] command_in;
    logic [WIDTH-1:0] data_in;
    logic             invoke;
    logic [1:0]       next_instr;
    logic [POP_W-1:0] data_pop;
    logic [POP_W-1:0] command_pop;
    logic             rd_in_command;
    logic             rd_in_data;
    logic             FC;
    logic             wr_out;
    logic [31:0]      data_out_result;
    logic [31:0]      data_out_status;
    logic [7:0]       instr;
    logic [4:0]       arg2;

    modport slave (
        input  command_in, data_in, invoke, next_instr, data_pop, command_pop,
        output rd_in_command, rd_in_data, FC, wr_out,
               data_out_result, data_out_status, instr, arg2
    );

    modport master (
        output command_in, data_in, invoke, next_instr, data_pop, command_pop,
        input  rd_in_command, rd_in_data, FC, wr_out,
               data_out_result, data_out_status, instr, arg2
    );
endinterface

// File: rtl/pea_core.sv
// Command-driven polynomial engine: 8 coefficient slots, Horner evaluation.
module pea_core #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned POP_W = 10
) (
    input  logic      clk,
    input  logic      rst,
    pea_core_if.slave bus
);
    localparam int unsigned NSLOT = 8;
    localparam int unsigned NCOEF = 32;
    localparam int unsigned RES_W = 32;
    localparam int unsigned MAC_W = 38;

    localparam logic [7:0] OP_RST = 8'h00;
    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_GC_RD, S_GC_CAP, S_STP_WAIT, S_STP_RD,
        S_STP_CAP, S_EV_LD, S_EV_ITER, S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic                     rd_cmd_q, rd_cmd_d;
    logic                     rd_dat_q, rd_dat_d;
    logic                     fc_q, fc_d;
    logic                     wr_q, wr_d;
    logic [RES_W-1:0]         res_q, res_d;
    logic [RES_W-1:0]         stat_q, stat_d;
    logic [7:0]               instr_q, instr_d;
    logic [4:0]               arg2_q, arg2_d;
    logic [2:0]               b_q, b_d;
    logic [NSLOT-1:0]         valid_q, valid_d;
    logic [4:0]               deg_q [NSLOT];
    logic [4:0]               deg_d [NSLOT];
    logic [4:0]               k_q, k_d;
    logic [4:0]               i_q, i_d;
    logic signed [RES_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;

    logic signed [WIDTH-1:0]  coef_q [NSLOT][NCOEF];

    logic                     pop_ok_c;
    logic signed [WIDTH-1:0]  coef_top_c;
    logic signed [WIDTH-1:0]  coef_nxt_c;
    logic signed [MAC_W-1:0]  mac_wide_c;
    logic                     mac_ovf_c;

    // One Horner step acc*x + c at full precision; overflow when it leaves signed 32-bit.
    always_comb begin
        pop_ok_c   = (bus.data_pop != POP_W'(0));
        coef_top_c = coef_q[b_q][deg_q[b_q]];
        coef_nxt_c = coef_q[b_q][5'(i_q - 5'd1)];
        mac_wide_c = MAC_W'(acc_q) * $signed(MAC_W'(arg2_q)) + MAC_W'(coef_nxt_c);
        mac_ovf_c  = (mac_wide_c[MAC_W-1:RES_W-1] != {(MAC_W-RES_W+1){mac_wide_c[RES_W-1]}});
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        arg2_d  = arg2_q;
        b_d     = b_q;
        valid_d = valid_q;
        deg_d   = deg_q;
        k_d     = k_q;
        i_d     = i_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        stat_d  = stat_q;
        wr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.invoke) begin
                    case (bus.next_instr)
                        2'b00: state_d = S_GC_RD;
                        2'b01: begin
                            case (instr_q)
                                OP_RST: begin
                                    valid_d = '0;
                                    state_d = S_DONE;
                                end
                                OP_STP: begin
                                    k_d     = 5'd0;
                                    state_d = pop_ok_c ? S_STP_RD : S_STP_WAIT;
                                end
                                OP_EVP: begin
                                    if (valid_q[b_q]) begin
                                        state_d = S_EV_LD;
                                    end else begin
                                        res_d   = '0;
                                        stat_d  = RES_W'(1);
                                        wr_d    = 1'b1;
                                        state_d = S_DONE;
                                    end
                                end
                                default: begin
                                    res_d   = '0;
                                    stat_d  = RES_W'(2);
                                    wr_d    = 1'b1;
                                    state_d = S_DONE;
                                end
                            endcase
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_GC_RD:  state_d = S_GC_CAP;
            S_GC_CAP: begin
                instr_d = bus.command_in[15:8];
                b_d     = bus.command_in[7:5];
                arg2_d  = bus.command_in[4:0];
                state_d = S_DONE;
            end
            S_STP_WAIT: begin
                if (pop_ok_c) state_d = S_STP_RD;
            end
            S_STP_RD: state_d = S_STP_CAP;
            S_STP_CAP: begin
                if (k_q == arg2_q) begin
                    deg_d[b_q]   = arg2_q;
                    valid_d[b_q] = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    state_d = pop_ok_c ? S_STP_RD : S_STP_WAIT;
                end
            end
            S_EV_LD: begin
                acc_d = RES_W'(coef_top_c);
                i_d   = deg_q[b_q];
                ovf_d = 1'b0;
                if (deg_q[b_q] == 5'd0) begin
                    res_d   = RES_W'(coef_top_c);
                    stat_d  = '0;
                    wr_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_EV_ITER;
                end
            end
            S_EV_ITER: begin
                acc_d = mac_wide_c[RES_W-1:0];
                ovf_d = ovf_q | mac_ovf_c;
                i_d   = i_q - 5'd1;
                if (i_q == 5'd1) begin
                    res_d   = mac_wide_c[RES_W-1:0];
                    stat_d  = (ovf_q | mac_ovf_c) ? RES_W'(3) : RES_W'(0);
                    wr_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_cmd_d = (state_d == S_GC_RD);
        rd_dat_d = (state_d == S_STP_RD);
        fc_d     = (state_d == S_DONE);
    end

    // State and control registers; reset aborts any firing in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_cmd_q <= 1'b0;
            rd_dat_q <= 1'b0;
            fc_q     <= 1'b0;
            wr_q     <= 1'b0;
            res_q    <= '0;
            stat_q   <= '0;
            instr_q  <= '0;
            arg2_q   <= '0;
            b_q      <= '0;
            valid_q  <= '0;
            deg_q    <= '{default: '0};
            k_q      <= '0;
            i_q      <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cmd_q <= rd_cmd_d;
            rd_dat_q <= rd_dat_d;
            fc_q     <= fc_d;
            wr_q     <= wr_d;
            res_q    <= res_d;
            stat_q   <= stat_d;
            instr_q  <= instr_d;
            arg2_q   <= arg2_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            deg_q    <= deg_d;
            k_q      <= k_d;
            i_q      <= i_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Coefficient RAM write; contents need no reset since valid flags gate use.
    always_ff @(posedge clk) begin
        if (state_q == S_STP_CAP) coef_q[b_q][k_q] <= bus.data_in;
    end

    assign bus.rd_in_command   = rd_cmd_q;
    assign bus.rd_in_data      = rd_dat_q;
    assign bus.FC              = fc_q;
    assign bus.wr_out          = wr_q;
    assign bus.data_out_result = res_q;
    assign bus.data_out_status = stat_q;
    assign bus.instr           = instr_q;
    assign bus.arg2            = arg2_q;
endmodule

// File: tb/tb_pea_core.sv
// Self-checking bench for pea_core with FIFO emulation and a behavioural model.
module tb_pea_core;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned POP_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pea_core_if #(.WIDTH(WIDTH), .POP_W(POP_W)) bus();
    pea_core #(.WIDTH(WIDTH), .POP_W(POP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // FIFO emulation: registered reads, word valid the cycle after the strobe.
    logic [15:0] dbuf [2048];
    logic [15:0] cbuf [256];
    int d_wr = 0, d_rd = 0, c_wr = 0, c_rd = 0;
    assign bus.data_pop    = POP_W'(d_wr - d_rd);
    assign bus.command_pop = POP_W'(c_wr - c_rd);

    always @(posedge clk) begin
        if (rst) begin
            d_rd <= d_wr;
            c_rd <= c_wr;
        end else begin
            if (bus.rd_in_data) begin
                bus.data_in <= dbuf[11'(d_rd)];
                d_rd <= d_rd + 1;
            end
            if (bus.rd_in_command) begin
                bus.command_in <= cbuf[8'(c_rd)];
                c_rd <= c_rd + 1;
            end
        end
    end

    // Reference model state.
    int mcoef [8][32];
    int mdeg  [8];
    bit mvalid [8];
    int m_rd = 0;
    logic [7:0] cur_op;
    int cur_b, cur_arg;
    logic [31:0] last_res;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void model_evp(input int b, input int x,
                                      output logic [31:0] r, output logic [31:0] s);
        longint acc, t;
        bit ov;
        if (!mvalid[b]) begin
            r = 32'd0;
            s = 32'd1;
            return;
        end
        acc = longint'(mcoef[b][mdeg[b]]);
        ov = 1'b0;
        for (int k = mdeg[b] - 1; k >= 0; k--) begin
            t = acc * longint'(x) + longint'(mcoef[b][k]);
            if (t > 64'sd2147483647 || t < -64'sd2147483648) ov = 1'b1;
            acc = longint'($signed(t[31:0]));
        end
        r = acc[31:0];
        s = ov ? 32'd3 : 32'd0;
    endfunction

    task automatic push_cmd(input logic [15:0] w);
        cbuf[8'(c_wr)] = w;
        c_wr++;
    endtask

    task automatic push_data(input logic [15:0] w);
        dbuf[11'(d_wr)] = w;
        d_wr++;
    endtask

    // One firing; latency counts cycles after the invoke edge, 0 means no FC seen.
    task automatic fire(input logic [1:0] mode, input int budget, output int lat, output int nwr,
                        output int nrd, output int nrc, output logic [31:0] res, output logic [31:0] stat);
        lat = 0; nwr = 0; nrd = 0; nrc = 0; res = '0; stat = '0;
        @(negedge clk);
        bus.invoke = 1'b1;
        bus.next_instr = mode;
        @(posedge clk);
        #1 bus.invoke = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (bus.rd_in_data) nrd++;
            if (bus.rd_in_command) nrc++;
            if (bus.wr_out) begin
                nwr++;
                res = bus.data_out_result;
                stat = bus.data_out_status;
            end
            if (bus.FC) begin
                lat = n;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            check("fc_pulse", 32'(bus.FC), 32'd0);
        end
    endtask

    task automatic setup(input logic [15:0] cmd);
        int lat, nwr, nrd, nrc;
        logic [31:0] r, s;
        push_cmd(cmd);
        fire(2'b00, 50, lat, nwr, nrd, nrc, r, s);
        check("setup_lat", 32'(lat), 32'd3);
        check("setup_rdc", 32'(nrc), 32'd1);
        check("setup_wr", 32'(nwr), 32'd0);
        check("setup_instr", 32'(bus.instr), 32'(cmd[15:8]));
        check("setup_arg2", 32'(bus.arg2), 32'(cmd[4:0]));
        cur_op = cmd[15:8];
        cur_b = int'(cmd[7:5]);
        cur_arg = int'(cmd[4:0]);
    endtask

    task automatic exec(input bit stalled);
        int lat, nwr, nrd, nrc, nom;
        logic [31:0] r, s, er, es;
        fire(2'b01, 400, lat, nwr, nrd, nrc, r, s);
        case (cur_op)
            8'h00: begin
                for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
                check("rst_lat", 32'(lat), 32'd1);
                check("rst_wr", 32'(nwr), 32'd0);
                check("rst_hold", bus.data_out_result, last_res);
            end
            8'h01: begin
                for (int k = 0; k <= cur_arg; k++)
                    mcoef[cur_b][k] = int'($signed(dbuf[11'(m_rd + k)]));
                m_rd += cur_arg + 1;
                mdeg[cur_b] = cur_arg;
                mvalid[cur_b] = 1'b1;
                nom = 2 * (cur_arg + 1) + 1;
                if (stalled) check("stp_lat_stall", 32'(lat > nom), 32'd1);
                else check("stp_lat", 32'(lat), 32'(nom));
                check("stp_reads", 32'(nrd), 32'(cur_arg + 1));
                check("stp_consumed", 32'(d_rd), 32'(m_rd));
                check("stp_wr", 32'(nwr), 32'd0);
                check("stp_hold", bus.data_out_result, last_res);
            end
            8'h02: begin
                model_evp(cur_b, cur_arg, er, es);
                check("evp_lat", 32'(lat), mvalid[cur_b] ? 32'(mdeg[cur_b] + 2) : 32'd1);
                check("evp_wr", 32'(nwr), 32'd1);
                check("evp_res", r, er);
                check("evp_stat", s, es);
                last_res = er;
            end
            default: begin
                check("bad_lat", 32'(lat), 32'd1);
                check("bad_wr", 32'(nwr), 32'd1);
                check("bad_res", r, 32'd0);
                check("bad_stat", s, 32'd2);
                last_res = 32'd0;
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, nwr, nrd, nrc, b, n, x, r8;
        logic [31:0] r, s;
        bus.invoke = 1'b0;
        bus.next_instr = 2'b00;
        last_res = 32'd0;
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdeg[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_rdc", 32'(bus.rd_in_command), 32'd0);
        check("rst_rdd", 32'(bus.rd_in_data), 32'd0);
        check("rst_fc", 32'(bus.FC), 32'd0);
        check("rst_wro", 32'(bus.wr_out), 32'd0);
        check("rst_res", bus.data_out_result, 32'd0);
        check("rst_stat", bus.data_out_status, 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_arg2", 32'(bus.arg2), 32'd0);
        rst = 1'b0;

        // Directed scenarios.
        push_data(16'd1); push_data(16'd2); push_data(16'd3); push_data(16'd4);
        setup(16'h0103);
        exec(1'b0);
        setup(16'h0202);
        exec(1'b0);
        check("tp_eval49", bus.data_out_result, 32'd49);
        setup(16'h0222);
        exec(1'b0);
        setup(16'hFF00);
        exec(1'b0);
        for (int i = 0; i < 8; i++) push_data(16'h7FFF);
        setup(16'h0147);
        exec(1'b0);
        setup(16'h025F);
        exec(1'b0);
        check("tp_ovf_stat", bus.data_out_status, 32'd3);
        setup(16'h0000);
        exec(1'b0);
        setup(16'h0202);
        exec(1'b0);
        check("tp_after_rst", bus.data_out_status, 32'd1);

        // Output firing: FC only.
        fire(2'b10, 20, lat, nwr, nrd, nrc, r, s);
        check("out_fc", 32'(lat != 0), 32'd1);
        check("out_wr", 32'(nwr), 32'd0);

        // Empty data FIFO at STP start: core stalls until words arrive.
        setup(16'h0123);
        fork
            exec(1'b1);
            begin
                repeat (12) @(negedge clk);
                for (int i = 0; i < 4; i++) push_data(16'($urandom));
            end
        join
        setup(16'h0225);
        exec(1'b0);

        // Reset in the middle of an STP firing.
        for (int i = 0; i < 6; i++) push_data(16'($urandom));
        setup(16'h0165);
        fork
            fire(2'b01, 20, lat, nwr, nrd, nrc, r, s);
            begin
                repeat (4) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("mid_rdd", 32'(bus.rd_in_data), 32'd0);
                check("mid_fc", 32'(bus.FC), 32'd0);
                check("mid_res", bus.data_out_result, 32'd0);
                check("mid_instr", 32'(bus.instr), 32'd0);
                check("mid_arg2", 32'(bus.arg2), 32'd0);
                rst = 1'b0;
            end
        join
        check("mid_no_fc", 32'(lat), 32'd0);
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        m_rd = d_wr;
        last_res = 32'd0;
        setup(16'h0222);
        exec(1'b0);

        // Randomized command mix.
        for (int it = 0; it < 16; it++) begin
            r8 = int'($urandom_range(0, 9));
            b = int'($urandom_range(0, 7));
            if (r8 < 5) begin
                n = int'($urandom_range(0, 12));
                for (int k = 0; k <= n; k++) push_data(16'($urandom));
                setup({8'h01, 3'(b), 5'(n)});
                exec(1'b0);
            end else if (r8 < 8) begin
                x = int'($urandom_range(0, 31));
                setup({8'h02, 3'(b), 5'(x)});
                exec(1'b0);
            end else if (r8 == 8) begin
                setup({8'h00, 3'(b), 5'd0});
                exec(1'b0);
            end else begin
                setup({8'($urandom_range(3, 255)), 3'(b), 5'($urandom_range(0, 31))});
                exec(1'b0);
            end
        end
        for (int sl = 0; sl < 8; sl++) begin
            setup({8'h02, 3'(sl), 5'($urandom_range(0, 31))});
            exec(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
